// File: rtl/imem_loader.sv
// imem_loader: copies a program image from backing storage into an
// instruction-memory partition, one word every two cycles (read, then write).
module imem_loader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 1000,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded,
    output logic              hd_re,
    output logic [ADDR_W-1:0] hd_addr,
    input  logic [DATA_W-1:0] hd_data,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    wl_q, wl_d;
    logic [ADDR_W-1:0]   hd_addr_q, hd_addr_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [DATA_W-1:0]   im_data_q, im_data_d;

    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [CNT_W-1:0]    idx_inc;
    logic [ADDR_W:0]     end_sum;
    logic                out_of_range;

    // Address/index arithmetic shared by next-state and output logic
    always_comb begin
        rd_addr      = src_q + ADDR_W'(idx_q);
        wr_addr      = dst_q + ADDR_W'(idx_q);
        idx_inc      = idx_q + CNT_W'(1);
        // one extra bit so a destination near the top of the address space cannot wrap into range
        end_sum      = {1'b0, dst_base} + (ADDR_W+1)'(num_words);
        out_of_range = end_sum > (ADDR_W+1)'(IMEM_DEPTH);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            wl_q      <= '0;
            hd_addr_q <= '0;
            im_addr_q <= '0;
            im_data_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            wl_q      <= wl_d;
            hd_addr_q <= hd_addr_d;
            im_addr_q <= im_addr_d;
            im_data_q <= im_data_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        num_d     = num_q;
        idx_d     = idx_q;
        wl_d      = wl_q;
        hd_addr_d = hd_addr_q;
        im_addr_d = im_addr_q;
        im_data_d = im_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src_base;
                    dst_d = dst_base;
                    num_d = num_words;
                    idx_d = '0;
                    wl_d  = '0;
                    if (out_of_range) begin
                        state_d = S_ERR;
                    end else if (num_words == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                hd_addr_d = rd_addr;
                state_d   = S_WR;
            end
            S_WR: begin
                im_addr_d = wr_addr;
                im_data_d = hd_data;
                idx_d     = idx_inc;
                wl_d      = wl_q + CNT_W'(1);
                state_d   = (idx_inc == num_q) ? S_DONE : S_REQ;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; addresses hold their last value when idle
    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        err          = (state_q == S_ERR);
        hd_re        = (state_q == S_REQ);
        im_we        = (state_q == S_WR);
        hd_addr      = hd_re ? rd_addr : hd_addr_q;
        im_addr      = im_we ? wr_addr : im_addr_q;
        im_data      = im_we ? hd_data : im_data_q;
        words_loaded = wl_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives directed and random copy requests and compares the
// observed reads/writes and handshake timing against a transfer-level model.
module tb_imem_loader;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int IMEM_DEPTH = 1000;
    localparam int CNT_W      = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [CNT_W-1:0]  num_words;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  words_loaded;
    logic              hd_re;
    logic [ADDR_W-1:0] hd_addr;
    logic [DATA_W-1:0] hd_data = '0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_data;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .IMEM_DEPTH(IMEM_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .num_words   (num_words),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded),
        .hd_re       (hd_re),
        .hd_addr     (hd_addr),
        .hd_data     (hd_data),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_data     (im_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] seed;

    // Storage content is a fixed function of the address
    function automatic logic [31:0] stor(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // Storage model: synchronous read, one-cycle latency
    always @(posedge clk) begin
        if (hd_re) hd_data <= stor(hd_addr);
    end

    // Commit log of reads and instruction-memory writes seen at clock edges
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          rd_cnt;

    always @(posedge clk) begin
        if (reset) begin
            if (im_we) begin
                wa.push_back(im_addr);
                wd.push_back(im_data);
            end
            if (hd_re) rd_cnt++;
        end
    end

    // One transfer: abort_k >= 0 pulls reset during the write of word abort_k.
    // chain leaves start asserted (with junk params) from the done cycle onward.
    task automatic do_xfer(input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] n, input bit poke, input bit chain,
                           input int abort_k);
        logic [32:0] endw;
        bit          exp_err;
        bit          aborted;
        int          c;
        int          done_c;
        int          err_c;
        int          busy_cnt;
        int          n_w;
        int          n_rd;
        endw     = {1'b0, dst} + 33'(n);
        exp_err  = (endw > 33'(IMEM_DEPTH));
        aborted  = 1'b0;
        done_c   = 0;
        err_c    = 0;
        busy_cnt = 0;
        wa.delete();
        wd.delete();
        rd_cnt   = 0;

        src_base  = src;
        dst_base  = dst;
        num_words = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        src_base  = $urandom;
        dst_base  = $urandom;
        num_words = 16'($urandom);
        c = 1;
        while (1) begin
            if (busy) busy_cnt++;
            if (done && done_c == 0) done_c = c;
            if (err && err_c == 0) err_c = c;
            if (abort_k >= 0 && c == 2 * abort_k + 2) begin
                check("abort_in_wr", im_we, 1);
                check("abort_wl_before", words_loaded, abort_k);
                #2 reset = 1'b0;
                #1;
                check("abort_we_async", im_we, 0);
                check("abort_ctrl", {busy, done, err, hd_re}, 0);
                check("abort_addrs", {hd_addr, im_addr}, 0);
                check("abort_data_wl", {im_data, 16'h0, words_loaded}, 0);
                repeat (2) @(negedge clk);
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (!busy) break;
            if (c > 200) begin
                check("xfer_timeout_busy", busy, 0);
                break;
            end
            start = 1'b0;
            if (poke && c == 4) begin
                start     = 1'b1;
                src_base  = src + 32'd77;
                dst_base  = dst ^ 32'd1;
                num_words = n + 16'd1;
            end
            if (chain && c == done_c) begin
                start     = 1'b1;
                src_base  = $urandom;
                dst_base  = 32'd0;
                num_words = 16'd3;
            end
            c++;
            @(negedge clk);
        end

        if (aborted) begin
            n_w  = abort_k;
            n_rd = abort_k + 1;
        end else begin
            n_w  = exp_err ? 0 : int'(n);
            n_rd = n_w;
            if (exp_err) begin
                check("err_cycle", err_c, 1);
                check("no_done", done_c, 0);
            end else begin
                check("done_cycle", done_c, 2 * int'(n) + 1);
                check("no_err", err_c, 0);
            end
            check("busy_cycles", busy_cnt, exp_err ? 1 : 2 * int'(n) + 1);
            check("words_loaded", words_loaded, n_w);
            check("idle_we", im_we, 0);
        end
        check("write_count", wa.size(), n_w);
        check("read_count", rd_cnt, n_rd);
        for (int k = 0; k < n_w && k < wa.size(); k++) begin
            check("wr_addr", wa[k], dst + 32'(k));
            check("wr_data", wd[k], stor(src + 32'(k)));
        end
    endtask

    initial begin
        seed      = $urandom;
        reset     = 1'b0;
        start     = 1'b0;
        src_base  = '0;
        dst_base  = '0;
        num_words = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {busy, done, err, hd_re, im_we}, 0);
        check("rst_hd_addr", hd_addr, 0);
        check("rst_im_addr", im_addr, 0);
        check("rst_im_data", im_data, 0);
        check("rst_wl", words_loaded, 0);
        reset = 1'b1;
        @(negedge clk);

        // directed cases
        do_xfer(32'd100, 32'd617, 16'd3, 0, 0, -1);
        @(negedge clk);
        do_xfer(32'd5, 32'd0, 16'd0, 0, 0, -1);
        @(negedge clk);
        do_xfer(32'd200, 32'd990, 16'd11, 0, 0, -1);
        @(negedge clk);
        do_xfer(32'd200, 32'd990, 16'd10, 0, 0, -1);
        @(negedge clk);
        do_xfer(32'd300, 32'd40, 16'd4, 1, 1, -1);
        do_xfer(32'd400, 32'd0, 16'd3, 0, 0, -1);
        @(negedge clk);
        do_xfer(32'd500, 32'd123, 16'd5, 0, 0, 2);
        @(negedge clk);
        do_xfer(32'd600, 32'd123, 16'd5, 0, 0, -1);
        @(negedge clk);
        do_xfer(32'hFFFF_FFFE, 32'd10, 16'd4, 0, 0, -1);
        @(negedge clk);
        do_xfer(32'd7, 32'd1000, 16'd0, 0, 0, -1);
        @(negedge clk);
        do_xfer(32'd7, 32'hFFFF_FFF0, 16'h0020, 0, 0, -1);
        @(negedge clk);
        do_xfer(32'd7, 32'd999, 16'd1, 0, 0, -1);

        // random cases, biased toward the top of the partition
        for (int t = 0; t < 20; t++) begin
            logic [31:0] rs;
            logic [31:0] rdst;
            logic [15:0] rn;
            rs   = $urandom;
            rn   = 16'($urandom_range(0, 20));
            rdst = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(975, 1010))
                                               : 32'($urandom_range(0, 1000));
            @(negedge clk);
            do_xfer(rs, rdst, rn, 0, 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory: copies a program image from backing storage (HD) into an instruction-memory partition, one word at a time.
- Started by the OS/control unit when a process is loaded. Supplies the write port (address, data, write enable) that the read-only fetch port does not have.
- Storage read port is synchronous with one-cycle latency: address sampled at a rising edge, data valid after that edge.

Parameters:
- ADDR_W, 32, width of storage and instruction-memory addresses
- DATA_W, 32, instruction word width
- IMEM_DEPTH, 1000, number of instruction-memory words; highest valid index is IMEM_DEPTH-1
- CNT_W, 16, width of the word-count field

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- src_base  in  ADDR_W  first storage word address
- dst_base  in  ADDR_W  first instruction-memory word address
- num_words  in  CNT_W  number of words to copy
- busy  out  1  high from acceptance until DONE exits
- done  out  1  one-cycle pulse, copy completed
- err  out  1  one-cycle pulse, request rejected
- words_loaded  out  CNT_W  words written in the current/last transfer
- hd_re  out  1  storage read strobe
- hd_addr  out  ADDR_W  storage read address
- hd_data  in  DATA_W  storage read data, valid the cycle after hd_re
- im_we  out  1  instruction-memory write enable
- im_addr  out  ADDR_W  instruction-memory write address
- im_data  out  DATA_W  instruction-memory write data

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. busy, done, err, hd_re, im_we = 0. hd_addr, im_addr, im_data, words_loaded = 0. Internal index and latched bases/count = 0.
- Reset asserted mid-transfer aborts it immediately: im_we drops without waiting for a clock edge. No done or err pulse. Partially written words remain in memory.
- States: IDLE, REQ, WR, DONE, ERR.
- IDLE, start=1 at edge E0:
  - latch src_base, dst_base, num_words; clear index i and words_loaded.
  - dst_base + num_words > IMEM_DEPTH (computed at ADDR_W+1 bits, so no wrap-around) -> ERR.
  - else num_words == 0 -> DONE.
  - else -> REQ.
- REQ: hd_re=1, hd_addr = src_base + i, busy=1. Next state WR.
- WR:
  - im_we=1, im_addr = dst_base + i, im_data = hd_data (combinational pass-through of the registered storage output). busy=1.
  - At the edge: i and words_loaded increment. If i+1 == num_words -> DONE, else -> REQ.
- Timing: word k has its read in the cycle after E(2k) and its write in the cycle after E(2k+1). done is high in the cycle after E(2N). Throughput is 2 cycles/word.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE. start is ignored in DONE; the earliest re-accept is the cycle after done.
- ERR: err=1 for one cycle, busy=1, then IDLE. No hd_re or im_we in an errored transfer.
- start in REQ/WR/DONE/ERR is ignored. Latched parameters are unaffected by changes on src_base/dst_base/num_words after acceptance.
- Outside WR: im_we=0, with im_addr/im_data holding their last values. Outside REQ: hd_re=0.
- words_loaded holds its final value in IDLE until the next accepted start.
- Address arithmetic is modulo 2^ADDR_W on the storage side. The destination side is guaranteed in range by the ERR check; exact fit (dst_base + num_words == IMEM_DEPTH) is legal.

Test Plan:
- Storage words 100..102 = A,B,C; start with src 100, dst 617, n=3 -> im_we pulses at addresses 617, 618, 619 with data A, B, C. done in the cycle after E6. words_loaded=3. busy is high for 7 cycles.
- n=0, dst 0 -> done in the cycle after E0; no hd_re or im_we; words_loaded=0.
- dst 990, n=11 -> err pulse, no writes. Then dst 990, n=10 -> accepted; last write at address 999, done after E20.
- start re-pulsed during WR of a 4-word copy with different bases -> ignored; the original 4 writes complete unchanged. start in the done cycle is ignored; start the next cycle is accepted.
- reset driven low in the WR cycle of word 2 of 5 -> im_we falls with no clock edge. All outputs go to 0 and state is IDLE. Words 0 and 1 are written; word 2 is not. A subsequent start works normally.
